// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : EX-stage multiply/divide unit. Sequences MULT/MULTU,
//            MADD/MADDU/MSUB/MSUBU (product plus HI/LO accumulate) and
//            DIV/DIVU (radix-2 restoring divider with sign fix-up).
//            Stalls EX while busy and issues one HI/LO write at the end.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int MUL_LAT = 2      // acceptance-to-product latency, 1..4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [1:0]  whilo_o
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_MUL  = 3'd1;
    localparam logic [2:0] c_ACC  = 3'd2;
    localparam logic [2:0] c_DIV  = 3'd3;
    localparam logic [2:0] c_SIGN = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    // Count value in the final MUL cycle; unused when MUL_LAT is 1
    localparam logic [5:0] c_MUL_LAST = (MUL_LAT > 1) ? 6'(MUL_LAT - 2) : 6'd0;
    localparam logic [5:0] c_DIV_LAST = 6'd31;

    logic [2:0]  r_state;
    logic [2:0]  w_next;

    // Operation context latched at acceptance
    logic        r_acc;      // accumulate op (MADD/MSUB family)
    logic        r_sub;      // MSUB/MSUBU
    logic        r_dvz;      // divide by zero
    logic        r_neg_q;    // quotient must be negated
    logic        r_neg_r;    // remainder must be negated
    logic [31:0] r_a;        // raw dividend, returned in HI on divide by zero
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_prod;
    logic [5:0]  r_cnt;

    // Divider working registers: quotient shifts in from the dividend
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;

    logic        w_accept;
    logic        w_is_div;
    logic        w_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [63:0] w_acc;
    logic [63:0] w_result;

    assign w_accept = (r_state == c_IDLE) && start_i && !flush_i;
    assign w_is_div = ~op_i[2] & op_i[1];
    assign w_signed = ~op_i[0];

    // Low 64 bits of the product of the 64-bit extended operands equal the
    // true signed/unsigned 32x32 product.
    assign w_a_ext = {{32{w_signed & src_a_i[31]}}, src_a_i};
    assign w_b_ext = {{32{w_signed & src_b_i[31]}}, src_b_i};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_a_mag = (w_signed && src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
    assign w_b_mag = (w_signed && src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;

    // One restoring step: remainder always stays below the divisor, so the
    // shifted value fits 33 bits and bit 32 of the difference is its sign.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[32];

    assign w_quo_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign w_rem_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;
    assign w_acc     = r_sub ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);

    assign stall_o = w_accept || ((r_state != c_IDLE) && (r_state != c_DONE));
    assign done_o  = (r_state == c_DONE);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; a flush cancels everything except DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_is_div) begin
                        w_next = (src_b_i == 32'd0) ? c_SIGN : c_DIV;
                    end else if (MUL_LAT == 1) begin
                        w_next = op_i[2] ? c_ACC : c_DONE;
                    end else begin
                        w_next = c_MUL;
                    end
                end
            end
            c_MUL: begin
                if (flush_i) begin
                    w_next = c_IDLE;
                end else if (r_cnt == c_MUL_LAST) begin
                    w_next = r_acc ? c_ACC : c_DONE;
                end
            end
            c_ACC:  w_next = flush_i ? c_IDLE : c_DONE;
            c_DIV: begin
                if (flush_i) begin
                    w_next = c_IDLE;
                end else if (r_cnt == c_DIV_LAST) begin
                    w_next = c_SIGN;
                end
            end
            c_SIGN: w_next = flush_i ? c_IDLE : c_DONE;
            c_DONE: w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Value written to HI/LO on the edge that enters DONE
    always_comb begin
        w_result = 64'd0;
        case (r_state)
            c_IDLE: w_result = w_prod;
            c_MUL:  w_result = r_prod;
            c_ACC:  w_result = w_acc;
            c_SIGN: w_result = r_dvz ? {r_a, 32'hFFFF_FFFF} : {w_rem_fix, w_quo_fix};
            default: w_result = 64'd0;
        endcase
    end

    // Operand capture, multiplier/divider datapath and HI/LO result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc   <= 1'b0;
            r_sub   <= 1'b0;
            r_dvz   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_a     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_prod  <= 64'd0;
            r_cnt   <= 6'd0;
            r_quo   <= 32'd0;
            r_rem   <= 32'd0;
            r_dvs   <= 32'd0;
            hi_o    <= 32'd0;
            lo_o    <= 32'd0;
            whilo_o <= 2'b00;
        end else begin
            if (w_accept) begin
                r_acc   <= op_i[2];
                r_sub   <= op_i[2] & op_i[1];
                r_dvz   <= w_is_div && (src_b_i == 32'd0);
                r_neg_q <= w_signed & (src_a_i[31] ^ src_b_i[31]);
                r_neg_r <= w_signed & src_a_i[31];
                r_a     <= src_a_i;
                r_hi    <= hi_i;
                r_lo    <= lo_i;
                r_prod  <= w_prod;
                r_cnt   <= 6'd0;
                r_quo   <= w_a_mag;
                r_rem   <= 32'd0;
                r_dvs   <= w_b_mag;
            end else if (r_state == c_MUL) begin
                r_cnt <= r_cnt + 6'd1;
            end else if (r_state == c_DIV) begin
                r_cnt <= r_cnt + 6'd1;
                r_quo <= {r_quo[30:0], w_ge};
                r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
            end

            if (w_next == c_DONE) begin
                hi_o    <= w_result[63:32];
                lo_o    <= w_result[31:0];
                whilo_o <= 2'b11;
            end else begin
                whilo_o <= 2'b00;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Self-checking bench for mdu_ctrl (MUL_LAT = 2). Expected HI/LO
//            and latency are queued when an op is issued and compared when
//            done_o is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [1:0]  whilo_o;

    mdu_ctrl #(.MUL_LAT(2)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (start_i),
        .op_i    (op_i),
        .src_a_i (src_a_i),
        .src_b_i (src_b_i),
        .hi_i    (hi_i),
        .lo_i    (lo_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .whilo_o (whilo_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          t0;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Result scoreboard: every done_o pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (resetn && done_o) begin
            if (q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check("hi", {32'd0, hi_o}, {32'd0, e.hi});
                check("lo", {32'd0, lo_o}, {32'd0, e.lo});
                check("whilo", {62'd0, whilo_o}, 64'd3);
                check("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    // Issue one op at the current negedge, hold start_i while stalled,
    // return at the negedge after done_o (the next acceptance slot).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         input logic [31:0] eh, input logic [31:0] el, input int lat);
        int  n_stall;
        int  k;
        bit  seen;
        q.push_back('{eh, el, cyc, lat});
        start_i = 1'b1;
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
        hi_i    = h;
        lo_i    = l;
        #1;
        n_stall = 0;
        seen    = 1'b0;
        k       = 0;
        while (!seen && k < 80) begin
            if (done_o) begin
                seen = 1'b1;
                check("stall_in_done", {63'd0, stall_o}, 64'd0);
            end else begin
                if (stall_o) n_stall++;
                @(negedge clk);
                k++;
            end
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("stall_cycles", 64'(n_stall), 64'(lat));
        start_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]        a, b;
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sq, sr;

        resetn  = 1'b0;
        start_i = 1'b0;
        op_i    = 3'd0;
        src_a_i = 32'd0;
        src_b_i = 32'd0;
        hi_i    = 32'd0;
        lo_i    = 32'd0;
        flush_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_whilo", {62'd0, whilo_o}, 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed ops: op, a, b, hi_i, lo_i, expected hi, expected lo, latency
        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0000_0001, 2);
        do_op(3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 3);
        do_op(3'd7, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
        do_op(3'd6, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10, 32'd0, 32'd16, 3);
        do_op(3'd5, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd1, 32'd2, 32'hFFFF_FFFF, 3);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        do_op(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFD, 34);
        do_op(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14, 34);
        do_op(3'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 32'hFFFF_FFFF, 2);
        do_op(3'd2, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 2);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 34);

        // Random multiplies and divides against arithmetic reference values
        for (int i = 0; i < 4; i++) begin
            a  = $urandom;
            b  = $urandom;
            sp = $signed(a) * $signed(b);
            do_op(3'd0, a, b, 32'd0, 32'd0, sp[63:32], sp[31:0], 2);
            up = {32'd0, a} * {32'd0, b};
            do_op(3'd1, a, b, 32'd0, 32'd0, up[63:32], up[31:0], 2);
            b = $urandom >> $urandom_range(0, 28);
            if (b == 32'd0) b = 32'd3;
            do_op(3'd3, a, b, 32'd0, 32'd0, a % b, a / b, 34);
            if (b == 32'hFFFF_FFFF) b = 32'd9;
            if (i[0]) b = ~b;
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            do_op(3'd2, a, b, 32'd0, 32'd0, sr, sq, 34);
        end

        // Flush a divide in flight, then issue a multiply straight away
        start_i = 1'b1;
        op_i    = 3'd2;
        src_a_i = 32'd1000;
        src_b_i = 32'd3;
        #1;
        check("flush_accept_stall", {63'd0, stall_o}, 64'd1);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check("flush_stall_drop", {63'd0, stall_o}, 64'd0);
        do_op(3'd1, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd12, 2);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of a divide
        start_i = 1'b1;
        op_i    = 3'd2;
        src_a_i = 32'd77;
        src_b_i = 32'd5;
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        resetn  = 1'b0;
        #1;
        check("arst_stall", {63'd0, stall_o}, 64'd0);
        check("arst_done", {63'd0, done_o}, 64'd0);
        check("arst_whilo", {62'd0, whilo_o}, 64'd0);
        check("arst_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);

        // start_i with flush_i in IDLE must not be accepted
        start_i = 1'b1;
        flush_i = 1'b1;
        op_i    = 3'd1;
        src_a_i = 32'd6;
        src_b_i = 32'd7;
        #1;
        check("flush_start_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check("flush_start_next", {63'd0, stall_o}, 64'd0);
        repeat (10) @(negedge clk);

        do_op(3'd0, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 2);
        repeat (5) @(negedge clk);

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
